// File: rtl/sdp_bram_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM.
// Sequencer states, collision policy codes and the byte-lane merge helper.
package sdp_bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned COLL_READ_FIRST  = 0;
  localparam int unsigned COLL_WRITE_FIRST = 1;

  // Widest word the merge helper supports; callers zero-extend and truncate.
  localparam int unsigned MAX_DW = 256;
  localparam int unsigned MAX_IW = 8;

  // Lane i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic logic [MAX_DW-1:0] be_merge(
    input logic [MAX_DW-1:0] old_word,
    input logic [MAX_DW-1:0] new_word,
    input logic [MAX_DW-1:0] be,
    input int unsigned       byte_width
  );
    logic [MAX_DW-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (be[MAX_IW'(i / byte_width)]) res[MAX_IW'(i)] = new_word[MAX_IW'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sdp_bram_core.sv
// Plain inferable RAM array: byte-enable write port, registered read port.
module sdp_bram_core #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]            wa,
  input  logic [DATA_WIDTH-1:0]            wd,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            ra,
  output logic [DATA_WIDTH-1:0]            rd
);

  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wbe[i]) mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read-first by construction: a same-edge write is not visible here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
    end else if (re) begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/sdp_bram_be.sv
// Simple dual-port RAM with byte enables, post-reset clear sweep,
// selectable collision policy and optional output register.
module sdp_bram_be
  import sdp_bram_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH     = 6,
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          BYTE_WIDTH     = 8,
  parameter int unsigned          OUT_REG        = 0,
  parameter int unsigned          WRITE_FIRST    = 0,
  parameter int unsigned          CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ready,
  input  logic [ADDR_WIDTH-1:0]            wa,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]            wd,
  input  logic [ADDR_WIDTH-1:0]            ra,
  input  logic                             re,
  output logic [DATA_WIDTH-1:0]            rd,
  output logic                             rd_valid
);

  localparam int unsigned NBYTES = DATA_WIDTH / BYTE_WIDTH;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    run;

  logic                    mem_we;
  logic [NBYTES-1:0]       mem_wbe;
  logic [ADDR_WIDTH-1:0]   mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;
  logic                    mem_re;
  logic [DATA_WIDTH-1:0]   mem_rd;

  logic                    coll;
  logic                    v1;
  logic                    coll_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  logic [NBYTES-1:0]       wbe_q;
  logic [DATA_WIDTH-1:0]   s1_data;

  // Clear sequencer: one word per cycle from address 0, then run forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_addr <= '0;
      ready    <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == '1) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign run = (state == ST_RUN);

  // Write port belongs to the sweep until it finishes.
  always_comb begin
    mem_we  = 1'b1;
    mem_wbe = '1;
    mem_wa  = clr_addr;
    mem_wd  = CLEAR_VALUE;
    if (run) begin
      mem_we  = we;
      mem_wbe = wbe;
      mem_wa  = wa;
      mem_wd  = wd;
    end
  end

  assign mem_re = run & re;
  assign coll   = run & re & we & (ra == wa) & (WRITE_FIRST == COLL_WRITE_FIRST);

  sdp_bram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .we  (mem_we),
    .wbe (mem_wbe),
    .wa  (mem_wa),
    .wd  (mem_wd),
    .re  (mem_re),
    .ra  (ra),
    .rd  (mem_rd)
  );

  // Capture the colliding write so the array's pre-write word can be patched next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      coll_q <= 1'b0;
      wd_q   <= '0;
      wbe_q  <= '0;
    end else begin
      v1 <= mem_re;
      if (mem_re) begin
        coll_q <= coll;
        wd_q   <= wd;
        wbe_q  <= wbe;
      end
    end
  end

  assign s1_data = coll_q
                 ? DATA_WIDTH'(be_merge(MAX_DW'(mem_rd), MAX_DW'(wd_q), MAX_DW'(wbe_q), BYTE_WIDTH))
                 : mem_rd;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd       <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= v1;
          if (v1) rd <= s1_data;
        end
      end
    end else begin : g_no_out_reg
      assign rd       = s1_data;
      assign rd_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_bram_be.sv
// Scoreboard bench for sdp_bram_be: three configurations driven in parallel.
module tb_sdp_bram_be;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [3:0]  wbe;
  logic [31:0] wd;
  logic [5:0]  wa, ra;

  logic        ready0, rv0, ready1, rv1, ready2, rv2;
  logic [31:0] rd0, rd1, rd2;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: defaults; u1: output register + write-first; u2: no clear sweep
  sdp_bram_be #(.OUT_REG(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .ready(ready0), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd0), .rd_valid(rv0));
  sdp_bram_be #(.OUT_REG(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .ready(ready1), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd1), .rd_valid(rv1));
  sdp_bram_be #(.OUT_REG(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u2 (
    .clk(clk), .rst(rst), .ready(ready2), .wa(wa), .we(we), .wbe(wbe), .wd(wd),
    .ra(ra), .re(re), .rd(rd2), .rd_valid(rv2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return res;
  endfunction

  // One cycle of stimulus in RUN; expectations pushed alongside.
  task automatic op(input logic w, input logic [5:0] aw, input logic [3:0] be,
                    input logic [31:0] d, input logic r, input logic [5:0] ar);
    exp_t e;
    @(posedge clk); #1;
    we = w; wa = aw; wbe = be; wd = d; re = r; ra = ar;
    if (r) begin
      e.due  = cyc + 1;
      e.data = model[ar];
      q0.push_back(e);
      e.due  = cyc + 2;
      e.data = (w && aw == ar) ? lane_merge(model[ar], d, be) : model[ar];
      q1.push_back(e);
    end
    if (w) model[aw] = lane_merge(model[aw], d, be);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0;
    end
  endtask

  // Counts edges from reset release to ready; optionally checks u2 and pokes ports during the sweep.
  task automatic wait_clear(input string tag, input bit first, input bit poke);
    int n;
    n = 0;
    while (!ready0 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (first && (n == 1 || n == 40)) begin
        check("u2_ready", 32'(ready2), 32'd1);
        check("u2_rd_idle", rd2, 32'h0);
        check("u2_valid_idle", 32'(rv2), 32'd0);
      end
      if (poke && n == 5) begin
        we = 1'b1; wa = 6'd7; wbe = 4'hF; wd = 32'hDEADBEEF; re = 1'b1; ra = 6'd7;
      end
      if (poke && n == 8) begin
        we = 1'b0; re = 1'b0;
      end
    end
    check(tag, 32'(n), 32'd64);
    check({tag, "_u1"}, 32'(ready1), 32'd1);
  endtask

  // Scoreboard: pop on each valid pulse, flag missing or unexpected ones.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rv0) begin
        if (q0.size() == 0) check("u0_spurious_valid", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("u0_latency", 32'(cyc), 32'(e.due));
          check("u0_rd", rd0, e.data);
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        check("u0_missing_valid", 32'd0, 32'd1);
      end
      if (rv1) begin
        if (q1.size() == 0) check("u1_spurious_valid", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("u1_latency", 32'(cyc), 32'(e.due));
          check("u1_rd", rd1, e.data);
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        check("u1_missing_valid", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; ra = '0; wd = '0; wbe = '0;
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", 32'(ready0), 32'd0);
    check("rst_rd0", rd0, 32'h0);
    check("rst_valid0", 32'(rv0), 32'd0);
    check("rst_ready1", 32'(ready1), 32'd0);
    check("rst_rd1", rd1, 32'h0);
    check("rst_ready2", 32'(ready2), 32'd1);
    rst = 1'b0;
    wait_clear("clear_len", 1'b1, 1'b0);

    // sweep left zeros everywhere
    for (int a = 0; a < 64; a++) op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'(a));
    idle(4);

    // byte-lane merge, then hold after re drops
    op(1'b1, 6'd5, 4'hF, 32'hAABBCCDD, 1'b0, 6'd0);
    op(1'b1, 6'd5, 4'h5, 32'h11223344, 1'b0, 6'd0);
    op(1'b1, 6'd6, 4'h0, 32'h12345678, 1'b0, 6'd0);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd6);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd5);
    idle(4);
    check("hold_rd0", rd0, 32'hAA22CC44);
    check("hold_valid0", 32'(rv0), 32'd0);
    check("hold_rd1", rd1, 32'hAA22CC44);
    check("hold_valid1", 32'(rv1), 32'd0);

    // same-address collision, then plain re-read
    op(1'b1, 6'd9, 4'h3, 32'hFFFFFFFF, 1'b1, 6'd9);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd9);
    idle(4);
    check("coll_after_rd0", rd0, 32'h0000FFFF);

    // back-to-back reads through the output register
    op(1'b1, 6'd1, 4'hF, 32'h1, 1'b0, 6'd0);
    op(1'b1, 6'd2, 4'hF, 32'h2, 1'b0, 6'd0);
    op(1'b1, 6'd3, 4'hF, 32'h3, 1'b0, 6'd0);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd1);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd2);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd3);
    idle(4);

    // random traffic over a narrow window to provoke collisions
    for (int i = 0; i < 200; i++)
      op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 4'($urandom),
         $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)));
    idle(4);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    // reset in the middle of the sweep restarts it from zero
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 32'h0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midclr_ready0", 32'(ready0), 32'd0);
    check("midclr_rd0", rd0, 32'h0);
    check("midclr_valid0", 32'(rv0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear("reclear_len", 1'b0, 1'b1);
    op(1'b0, 6'd0, 4'h0, 32'h0, 1'b1, 6'd7);
    idle(4);
    check("reclear_addr7", rd0, 32'h0);
    check("q0_final", 32'(q0.size()), 32'd0);
    check("q1_final", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
